m_seq_multiplier: RTL and testbench

Parametrised, multi-cycle signed multiplier for the ALU datapath. It replaces the fixed 8-bit combinational multiplier with a radix-2 Booth shift-add engine. The engine takes `WIDTH` cycles per operation, returns the full `2*WIDTH` product plus the truncated `WIDTH`-bit ALU result, and flags signed overflow. It sits beside the other ALU function units. The control unit starts it with `START` and stalls the pipeline while `BUSY` is high.

---
 rtl/m_seq_multiplier_pkg.sv | 12 +
 rtl/m_booth_step.sv | 31 +++
 rtl/m_seq_multiplier.sv | 105 ++++++++++
 tb/tb_m_seq_multiplier.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_seq_multiplier_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM encoding and default width.
package m_seq_multiplier_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_t;

endpackage

// File: rtl/m_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into the accumulator,
// then an arithmetic right shift of the combined {A, Q, q-1} register.
module m_booth_step
    import m_seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH:0]   mcand,
    input  logic [WIDTH-1:0] mplier,
    input  logic             q_m1,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] mplier_nxt,
    output logic             q_m1_nxt
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case ({mplier[0], q_m1})
            2'b10:   sum = acc - mcand;
            2'b01:   sum = acc + mcand;
            default: sum = acc;
        endcase
    end

    // Sign bit of the accumulator is replicated into the vacated top position.
    assign {acc_nxt, mplier_nxt, q_m1_nxt} = {sum[WIDTH], sum, mplier};

endmodule

// File: rtl/m_seq_multiplier.sv
// Multi-cycle signed multiplier: WIDTH Booth steps per operation, full product, truncated
// ALU result and signed-overflow flag, all registered and held until the next completion.
module m_seq_multiplier
    import m_seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic [WIDTH-1:0]     DATA1,
    input  logic [WIDTH-1:0]     DATA2,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic [WIDTH-1:0]     OUTPUT,
    output logic                 OVERFLOW
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t            state_q;
    logic [WIDTH:0]    acc_q;
    logic [WIDTH:0]    mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic              q_m1_q;
    logic [CW-1:0]     cnt_q;

    logic [WIDTH:0]     acc_d;
    logic [WIDTH-1:0]   mplier_d;
    logic               q_m1_d;
    logic [2*WIDTH-1:0] prod_d;
    logic               ovf_d;

    m_booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc        (acc_q),
        .mcand      (mcand_q),
        .mplier     (mplier_q),
        .q_m1       (q_m1_q),
        .acc_nxt    (acc_d),
        .mplier_nxt (mplier_d),
        .q_m1_nxt   (q_m1_d)
    );

    // The accumulator's extra guard bit is dropped; the product fits in 2*WIDTH bits.
    assign prod_d = {acc_d[WIDTH-1:0], mplier_d};
    assign ovf_d  = ~((&prod_d[2*WIDTH-1:WIDTH-1]) | ~(|prod_d[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            q_m1_q   <= 1'b0;
            cnt_q    <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PRODUCT  <= '0;
            OUTPUT   <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StFin: begin
                    DONE <= 1'b0;
                    if (START) begin
                        state_q  <= StRun;
                        mcand_q  <= {DATA1[WIDTH-1], DATA1};
                        mplier_q <= DATA2;
                        acc_q    <= '0;
                        q_m1_q   <= 1'b0;
                        cnt_q    <= '0;
                        BUSY     <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        BUSY    <= 1'b0;
                    end
                end
                StRun: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    q_m1_q   <= q_m1_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q  <= StFin;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        PRODUCT  <= prod_d;
                        OUTPUT   <= prod_d[WIDTH-1:0];
                        OVERFLOW <= ovf_d;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_seq_multiplier.sv
// Scoreboard bench for the sequential Booth multiplier at WIDTH=8 and WIDTH=16.
module tb_m_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, busy, done, ovf;
    logic [7:0]  d1, d2, res;
    logic [15:0] prod;

    logic        rst16_n, start16, busy16, done16, ovf16;
    logic [15:0] e1, e2, res16;
    logic [31:0] prod16;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp8_q[$];
    logic [31:0] exp16_q[$];

    m_seq_multiplier #(.WIDTH(8)) dut8 (
        .CLK(clk), .RESET_N(rst_n), .START(start), .DATA1(d1), .DATA2(d2),
        .BUSY(busy), .DONE(done), .PRODUCT(prod), .OUTPUT(res), .OVERFLOW(ovf)
    );

    m_seq_multiplier #(.WIDTH(16)) dut16 (
        .CLK(clk), .RESET_N(rst16_n), .START(start16), .DATA1(e1), .DATA2(e2),
        .BUSY(busy16), .DONE(done16), .PRODUCT(prod16), .OUTPUT(res16), .OVERFLOW(ovf16)
    );

    function automatic logic [15:0] mul8(input logic signed [7:0] a, input logic signed [7:0] b);
        logic signed [15:0] p;
        p = a * b;
        return p;
    endfunction

    function automatic logic [31:0] mul16(input logic signed [15:0] a,
                                          input logic signed [15:0] b);
        logic signed [31:0] p;
        p = a * b;
        return p;
    endfunction

    function automatic logic ovf8_model(input logic [15:0] p);
        int v;
        v = int'($signed(p));
        return (v > 127) || (v < -128);
    endfunction

    function automatic logic ovf16_model(input logic [31:0] p);
        longint v;
        v = longint'($signed(p));
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic logic [15:0] pop8();
        if (exp8_q.size() == 0) return 16'hxxxx;
        return exp8_q.pop_front();
    endfunction

    function automatic logic [31:0] pop16();
        if (exp16_q.size() == 0) return 32'hxxxxxxxx;
        return exp16_q.pop_front();
    endfunction

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic go8(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1; d1 = a; d2 = b;
        exp8_q.push_back(mul8(a, b));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic go16(input logic [15:0] a, input logic [15:0] b);
        start16 = 1'b1; e1 = a; e2 = b;
        exp16_q.push_back(mul16(a, b));
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic wait8(output int cyc, output logic seen);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            seen = done;
        end
    endtask

    task automatic wait16(output int cyc, output logic seen);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            seen = done16;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst16_n = 1'b0;
        start = 1'b0; start16 = 1'b0;
        d1 = 8'h11; d2 = 8'h22; e1 = 16'h1234; e2 = 16'h5678;
        #12;
        n_cmp++;
        if ({busy, done, prod, res, ovf} !== 27'b0) begin
            n_bad++;
            $display("FAIL reset8: got %h required 0", {busy, done, prod, res, ovf});
        end
        n_cmp++;
        if ({busy16, done16, prod16, res16, ovf16} !== 51'b0) begin
            n_bad++;
            $display("FAIL reset16: got %h required 0", {busy16, done16, prod16, res16, ovf16});
        end
        @(posedge clk); #1;
        rst_n = 1'b1; rst16_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b required 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        int c; logic s; logic [15:0] e;
        go8(8'd3, 8'd5);
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_bad++;
            $display("FAIL busy_in_run: got %b required 10", {busy, done});
        end
        wait8(c, s);
        e = pop8();
        n_cmp++;
        if (!s || c != 8) begin
            n_bad++;
            $display("FAIL latency_3x5: got %0d (seen %b) required 8", c, s);
        end
        n_cmp++;
        if (prod !== 16'h000F || prod !== e) begin
            n_bad++;
            $display("FAIL product_3x5: got %h required %h", prod, e);
        end
        n_cmp++;
        if (res !== e[7:0] || ovf !== ovf8_model(e) || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL out_ovf_busy_3x5: got %h/%b/%b required %h/%b/0",
                     res, ovf, busy, e[7:0], ovf8_model(e));
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || prod !== e) begin
            n_bad++;
            $display("FAIL hold_3x5: got done=%b prod=%h required done=0 prod=%h", done, prod, e);
        end
    endtask

    task automatic test_back_to_back();
        int c; int gap; logic s; logic [15:0] e;
        start = 1'b1; d1 = 8'd10; d2 = 8'hFB;
        exp8_q.push_back(mul8(8'd10, 8'hFB));
        @(posedge clk); #1;
        d1 = 8'hFD; d2 = 8'hFB;
        exp8_q.push_back(mul8(8'hFD, 8'hFB));
        wait8(c, s);
        e = pop8();
        n_cmp++;
        if (!s || prod !== e || prod !== 16'hFFCE || res !== 8'hCE || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL first_b2b: got %h/%h/%b required %h/%h/%b",
                     prod, res, ovf, e, e[7:0], ovf8_model(e));
        end
        gap = 0;
        @(posedge clk); #1;
        gap++;
        start = 1'b0;
        while (!done && gap < 40) begin
            @(posedge clk); #1;
            gap++;
        end
        e = pop8();
        n_cmp++;
        if (gap != 9) begin
            n_bad++;
            $display("FAIL b2b_gap: got %0d required 9", gap);
        end
        n_cmp++;
        if (prod !== e || prod !== 16'd15 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL second_b2b: got %h/%b required %h/0", prod, ovf, e);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  ta[3] = '{8'h80, 8'h7F, 8'h80};
        logic [7:0]  tb_[3] = '{8'h80, 8'h7F, 8'h01};
        logic [15:0] tp[3] = '{16'h4000, 16'h3F01, 16'hFF80};
        int c; logic s; logic [15:0] e;
        for (int i = 0; i < 3; i++) begin
            go8(ta[i], tb_[i]);
            wait8(c, s);
            e = pop8();
            n_cmp++;
            if (!s || prod !== e || prod !== tp[i] || res !== e[7:0] ||
                ovf !== ovf8_model(e)) begin
                n_bad++;
                $display("FAIL corner%0d: got %h/%h/%b required %h/%h/%b",
                         i, prod, res, ovf, e, e[7:0], ovf8_model(e));
            end
        end
    endtask

    task automatic test_ignore_start();
        int c; int extra; logic s; logic [15:0] e;
        go8(8'd9, 8'hF9);
        d1 = 8'h55; d2 = 8'h66;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; d1 = 8'h37; d2 = 8'h42;
        @(posedge clk); #1;
        start = 1'b0;
        wait8(c, s);
        e = pop8();
        n_cmp++;
        if (!s || prod !== e) begin
            n_bad++;
            $display("FAIL ignore_start: got %h required %h", prod, e);
        end
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        n_cmp++;
        if (extra != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got %0d extra (busy %b) required 0", extra, busy);
        end
    endtask

    task automatic test_reset_mid();
        int c; int seen_done; logic s; logic [15:0] e;
        go8(8'd20, 8'd20);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(exp8_q.pop_back());
        #1;
        n_cmp++;
        if ({busy, done, prod, res, ovf} !== 27'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got %h required 0", {busy, done, prod, res, ovf});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        n_cmp++;
        if (seen_done != 0) begin
            n_bad++;
            $display("FAIL no_done_after_abort: got %0d required 0", seen_done);
        end
        go8(8'd6, 8'd7);
        wait8(c, s);
        e = pop8();
        n_cmp++;
        if (!s || prod !== e || prod !== 16'd42) begin
            n_bad++;
            $display("FAIL post_reset_6x7: got %h required %h", prod, e);
        end
    endtask

    task automatic test_width16();
        int c; logic s; logic [31:0] e;
        go16(16'd300, 16'hFF38);
        wait16(c, s);
        e = pop16();
        n_cmp++;
        if (!s || c != 16) begin
            n_bad++;
            $display("FAIL latency16: got %0d (seen %b) required 16", c, s);
        end
        n_cmp++;
        if (prod16 !== e || prod16 !== 32'hFFFF15A0 || res16 !== e[15:0] ||
            ovf16 !== ovf16_model(e)) begin
            n_bad++;
            $display("FAIL w16_300x-200: got %h/%h/%b required %h/%h/%b",
                     prod16, res16, ovf16, e, e[15:0], ovf16_model(e));
        end
    endtask

    task automatic test_random();
        int c; logic s; logic [31:0] e; logic [15:0] f;
        for (int i = 0; i < 12; i++) begin
            go16(16'($urandom), 16'($urandom));
            wait16(c, s);
            e = pop16();
            n_cmp++;
            if (!s || prod16 !== e || ovf16 !== ovf16_model(e)) begin
                n_bad++;
                $display("FAIL rand16_%0d: got %h/%b required %h/%b",
                         i, prod16, ovf16, e, ovf16_model(e));
            end
        end
        for (int i = 0; i < 12; i++) begin
            go8(8'($urandom), 8'($urandom));
            wait8(c, s);
            f = pop8();
            n_cmp++;
            if (!s || prod !== f || res !== f[7:0] || ovf !== ovf8_model(f)) begin
                n_bad++;
                $display("FAIL rand8_%0d: got %h/%b required %h/%b",
                         i, prod, ovf, f, ovf8_model(f));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_corners();
        test_ignore_start();
        test_reset_mid();
        test_width16();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
